// File: rtl/store_merge_unit.sv
// Store path: narrows a register value to byte/half/word and writes it to a word-wide memory port.
// Optional macro STORE_BYTE_ENABLE_EN replaces read-modify-write with lane enables and replicated data.
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t state;
    logic   misaligned;

    // NOTE: always_comb assigns misaligned on every path, so no latch can be inferred.
    always_comb begin
        misaligned = (size == 2'b11)
                  || (size == SZ_HALF && addr[0])
                  || (size == SZ_WORD && addr[1:0] != 2'b00);
    end

`ifdef STORE_BYTE_ENABLE_EN
    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        if (sz == SZ_BYTE)
            return 4'b0001 << off;
        return off[1] ? 4'b1100 : 4'b0011;
    endfunction
`else
    logic [31:0] data_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    // Little-endian merge: only the addressed lanes take the new data.
    function automatic logic [31:0] merge_word(input logic [31:0] rdata, input logic [31:0] data,
                                               input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] w;
        w = rdata;
        if (sz == SZ_BYTE)
            w[{off, 3'b000} +: 8] = data[7:0];
        else if (off[1])
            w[31:16] = data[15:0];
        else
            w[15:0] = data[15:0];
        return w;
    endfunction
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the latched operands are reset too; a dropped transaction leaves no stale data behind.
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'b0000;
`ifndef STORE_BYTE_ENABLE_EN
            data_q    <= '0;
            size_q    <= '0;
            off_q     <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (misaligned) begin
                            err <= 1'b1;
                        end else begin
                            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                            busy     <= 1'b1;
                            mem_req  <= 1'b1;
                            if (size == SZ_WORD) begin
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= wdata;
                                mem_be    <= 4'b1111;
                            end else begin
`ifdef STORE_BYTE_ENABLE_EN
                                state     <= WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= (size == SZ_BYTE) ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
                                mem_be    <= lane_mask(size, addr[1:0]);
`else
                                state  <= RD;
                                mem_we <= 1'b0;
                                mem_be <= 4'b0000;
                                data_q <= wdata;
                                size_q <= size;
                                off_q  <= addr[1:0];
`endif
                            end
                        end
                    end
                end
                RD: begin
`ifndef STORE_BYTE_ENABLE_EN
                    if (mem_ack) begin
                        state     <= WR;
                        mem_we    <= 1'b1;
                        mem_wdata <= merge_word(mem_rdata, data_q, size_q, off_q);
                        mem_be    <= 4'b1111;
                    end
`else
                    state <= IDLE;
`endif
                end
                WR: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a handshake memory model and hand-computed expectations.
// Expectations follow STORE_BYTE_ENABLE_EN when the bench is built with that macro.
module tb_store_merge_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        size;
    logic              busy, done, err, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr), .wdata(wdata), .size(size),
        .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } xfer_t;

    int checks = 0;
    int errors = 0;

    xfer_t       log_q[$];
    xfer_t       pend;
    xfer_t       prev_x;
    logic        prev_req   = 1'b0;
    int          ack_delay  = 0;
    int          wait_cnt   = 0;
    int          stable_err = 0;
    int          req_cycles = 0;
    int          done_cnt   = 0;
    int          both_cnt   = 0;
    logic [31:0] rd_value   = '0;

    // Memory model: acks after ack_delay idle request cycles, logs each completed transfer.
    always @(negedge clk) begin
        xfer_t cur;
        cur.we    = mem_we;
        cur.addr  = mem_addr;
        cur.wdata = mem_wdata;
        cur.be    = mem_be;
        if (mem_ack)
            log_q.push_back(pend);
        if (mem_req && prev_req && !mem_ack && cur != prev_x)
            stable_err++;
        prev_req = mem_req;
        prev_x   = cur;
        if (mem_req) req_cycles++;
        if (done) done_cnt++;
        if (done && err) both_cnt++;
        mem_ack = 1'b0;
        if (mem_req && !reset) begin
            if (wait_cnt >= ack_delay) begin
                pend      = cur;
                mem_ack   = 1'b1;
                mem_rdata = rd_value;
                wait_cnt  = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_xfer(input string tag, input int idx, input logic we, input logic [31:0] a,
                              input logic check_data, input logic [31:0] d, input logic [3:0] be);
        if (idx >= log_q.size()) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_we"}, {31'd0, log_q[idx].we}, {31'd0, we});
            check({tag, "_addr"}, log_q[idx].addr, a);
            if (check_data)
                check({tag, "_wdata"}, log_q[idx].wdata, d);
            check({tag, "_be"}, {28'd0, log_q[idx].be}, {28'd0, be});
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        wdata = d;
        size  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns cycles from the start cycle to the cycle done is high, then checks the pulse ends.
    task automatic wait_done(input string tag, output int lat);
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [1:0]  s;
    } bad_t;

    initial begin
        int   lat;
        int   req_before;
        int   done_before;
        bad_t bad[3];

        reset = 1'b1; start = 1'b0; addr = '0; wdata = '0; size = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        reset = 1'b0;

        // Word store, immediate ack.
        log_q.delete(); ack_delay = 0;
        issue(32'h100, 32'hDEADBEEF, 2'b10);
        wait_done("word", lat);
        check("word_lat", lat, 32'd2);
        check("word_nxfer", log_q.size(), 32'd1);
        check_xfer("word_wr", 0, 1'b1, 32'h100, 1'b1, 32'hDEADBEEF, 4'b1111);

        // Byte store at lane 3.
        log_q.delete(); rd_value = 32'h11223344;
        issue(32'h203, 32'h000000AB, 2'b00);
        wait_done("byte", lat);
`ifdef STORE_BYTE_ENABLE_EN
        check("byte_lat", lat, 32'd2);
        check("byte_nxfer", log_q.size(), 32'd1);
        check_xfer("byte_wr", 0, 1'b1, 32'h200, 1'b1, 32'hABABABAB, 4'b1000);
`else
        check("byte_lat", lat, 32'd3);
        check("byte_nxfer", log_q.size(), 32'd2);
        check_xfer("byte_rd", 0, 1'b0, 32'h200, 1'b0, 32'h0, 4'b0000);
        check_xfer("byte_wr", 1, 1'b1, 32'h200, 1'b1, 32'hAB223344, 4'b1111);
`endif

        // Upper halfword with three wait cycles per transfer.
        log_q.delete(); rd_value = 32'h55667788; ack_delay = 3; stable_err = 0;
        issue(32'h302, 32'h0000CAFE, 2'b01);
        wait_done("half", lat);
        check("half_stable", stable_err, 32'd0);
`ifdef STORE_BYTE_ENABLE_EN
        check("half_lat", lat, 32'd5);
        check("half_nxfer", log_q.size(), 32'd1);
        check_xfer("half_wr", 0, 1'b1, 32'h300, 1'b1, 32'hCAFECAFE, 4'b1100);
`else
        check("half_lat", lat, 32'd9);
        check("half_nxfer", log_q.size(), 32'd2);
        check_xfer("half_rd", 0, 1'b0, 32'h300, 1'b0, 32'h0, 4'b0000);
        check_xfer("half_wr", 1, 1'b1, 32'h300, 1'b1, 32'hCAFE7788, 4'b1111);
`endif

        // Misaligned and reserved-size requests.
        ack_delay = 0; log_q.delete(); req_before = req_cycles;
        bad[0] = '{a: 32'h401, s: 2'b01};
        bad[1] = '{a: 32'h402, s: 2'b10};
        bad[2] = '{a: 32'h400, s: 2'b11};
        for (int i = 0; i < 3; i++) begin
            issue(bad[i].a, 32'h12345678, bad[i].s);
            check($sformatf("bad%0d_err", i), {31'd0, err}, 32'd1);
            check($sformatf("bad%0d_busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("bad%0d_req", i), {31'd0, mem_req}, 32'd0);
            check($sformatf("bad%0d_done", i), {31'd0, done}, 32'd0);
            @(negedge clk);
            check($sformatf("bad%0d_err_pulse", i), {31'd0, err}, 32'd0);
        end
        check("bad_req_cycles", req_cycles - req_before, 32'd0);
        check("bad_nxfer", log_q.size(), 32'd0);

        // start held high while busy is ignored.
        log_q.delete();
        @(negedge clk);
        start = 1'b1; addr = 32'h500; wdata = 32'h12345678; size = 2'b10;
        @(negedge clk);
        check("ign_busy", {31'd0, busy}, 32'd1);
        addr = 32'h504; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        check("ign_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("ign_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("ign_still_idle", {31'd0, busy}, 32'd0);
        check("ign_nxfer", log_q.size(), 32'd1);
        check_xfer("ign_wr", 0, 1'b1, 32'h500, 1'b1, 32'h12345678, 4'b1111);

        // Reset while waiting on the first transfer.
        ack_delay = 1000; done_before = done_cnt;
        issue(32'h203, 32'h00000077, 2'b00);
        check("rstmid_busy", {31'd0, busy}, 32'd1);
        check("rstmid_req", {31'd0, mem_req}, 32'd1);
`ifdef STORE_BYTE_ENABLE_EN
        check("rstmid_we", {31'd0, mem_we}, 32'd1);
`else
        check("rstmid_we", {31'd0, mem_we}, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_req_drop", {31'd0, mem_req}, 32'd0);
        check("rstmid_busy_drop", {31'd0, busy}, 32'd0);
        check("rstmid_no_done", {31'd0, done}, 32'd0);
        check("rstmid_no_err", {31'd0, err}, 32'd0);
        reset = 1'b0; ack_delay = 0;
        @(negedge clk);
        check("rstmid_done_cnt", done_cnt - done_before, 32'd0);
        log_q.delete();
        issue(32'h600, 32'hCAFEF00D, 2'b10);
        wait_done("post", lat);
        check("post_lat", lat, 32'd2);
        check("post_nxfer", log_q.size(), 32'd1);
        check_xfer("post_wr", 0, 1'b1, 32'h600, 1'b1, 32'hCAFEF00D, 4'b1111);

        check("done_err_overlap", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
